// File: rtl/axi_eth_rxs.sv
// axi_eth_rxs: receive-side stream splitter for an AXI Ethernet S2MM path.
// Frame data passes straight through to the S2MM data stream. Each completed
// frame's byte count is queued in a small length FIFO. A status FSM then emits
// one six-word status packet per frame on the S2MM status stream.
// Optional feature macro: AXI_ETH_RXS_FRAME_CNT_EN. When it is defined, each
// status packet also carries a 16-bit frame number in APP3.
module axi_eth_rxs #(
    parameter int unsigned C_LEN_FIFO_DEPTH = 4
) (
    input  logic        s2mm_clk,
    input  logic        rx_reset,

    input  logic [63:0] mac_tdata,
    input  logic [7:0]  mac_tkeep,
    input  logic        mac_tlast,
    input  logic        mac_tvalid,
    output logic        mac_tready,

    output logic [63:0] rxd_tdata,
    output logic [7:0]  rxd_tkeep,
    output logic        rxd_tlast,
    output logic        rxd_tvalid,
    input  logic        rxd_tready,

    output logic [31:0] rxs_tdata,
    output logic [3:0]  rxs_tkeep,
    output logic        rxs_tlast,
    output logic        rxs_tvalid,
    input  logic        rxs_tready
);

    localparam int unsigned PTR_W = (C_LEN_FIFO_DEPTH > 1) ? $clog2(C_LEN_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
`ifdef AXI_ETH_RXS_FRAME_CNT_EN
    localparam int unsigned ENTRY_W = 32;
`else
    localparam int unsigned ENTRY_W = 16;
`endif

    localparam logic S_IDLE = 1'b0;
    localparam logic S_SEND = 1'b1;

    logic [15:0]        acc_q;
    logic [3:0]         keep_cnt;
    logic [16:0]        len_sum;
    logic [15:0]        len_sat;
    logic               beat_acc;
    logic               push;
    logic               pop;
    logic               len_full;
    logic               fifo_empty;

    logic [ENTRY_W-1:0] mem_q [C_LEN_FIFO_DEPTH];
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    logic               state_q;
    logic [2:0]         idx_q;
    logic [15:0]        len_q;
    logic [31:0]        app3;

`ifdef AXI_ETH_RXS_FRAME_CNT_EN
    logic [15:0]        frame_q;
    logic [15:0]        fno_q;
`endif

    // Data path: zero-latency pass-through, blocked only by a full length FIFO.
    // len_full comes from registered occupancy, so a same-cycle pop does not
    // unblock the beat.
    assign len_full   = (count_q == CNT_W'(C_LEN_FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);

    assign rxd_tdata  = mac_tdata;
    assign rxd_tkeep  = mac_tkeep;
    assign rxd_tlast  = mac_tlast;
    assign rxd_tvalid = mac_tvalid & ~len_full;
    assign mac_tready = rxd_tready & ~len_full;

    assign beat_acc = mac_tvalid & mac_tready;
    assign push     = beat_acc & mac_tlast;
    assign pop      = (state_q == S_IDLE) & ~fifo_empty;

    // Count every set keep bit; sparse keeps are counted as-is.
    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < 8; i++) begin
            keep_cnt = keep_cnt + {3'b000, mac_tkeep[i]};
        end
    end

    // The running total saturates at 0xFFFF instead of wrapping.
    assign len_sum = {1'b0, acc_q} + {13'd0, keep_cnt};
    assign len_sat = len_sum[16] ? 16'hFFFF : len_sum[15:0];

    // Length accumulator: add on each accepted beat; clear on the frame's last beat.
    always_ff @(posedge s2mm_clk) begin
        if (rx_reset) begin
            acc_q <= '0;
        end else if (beat_acc) begin
            acc_q <= mac_tlast ? 16'h0000 : len_sat;
        end
    end

`ifdef AXI_ETH_RXS_FRAME_CNT_EN
    assign wr_entry = {frame_q, len_sat};

    // Frame counter: advance and wrap on every length push.
    always_ff @(posedge s2mm_clk) begin
        if (rx_reset) begin
            frame_q <= '0;
        end else if (push) begin
            frame_q <= frame_q + 16'd1;
        end
    end
`else
    assign wr_entry = len_sat;
`endif

    assign rd_entry = mem_q[rd_ptr_q];

    // FIFO storage: contents need no reset because occupancy gates every read.
    always_ff @(posedge s2mm_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // FIFO pointers and occupancy. A simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge s2mm_clk) begin
        if (rx_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Status FSM: pop one length entry in S_IDLE, then walk six status words in S_SEND.
    always_ff @(posedge s2mm_clk) begin
        if (rx_reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
`ifdef AXI_ETH_RXS_FRAME_CNT_EN
            fno_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        len_q   <= rd_entry[15:0];
`ifdef AXI_ETH_RXS_FRAME_CNT_EN
                        fno_q   <= rd_entry[31:16];
`endif
                        idx_q   <= '0;
                        state_q <= S_SEND;
                    end
                end
                default: begin
                    if (rxs_tready) begin
                        if (idx_q == 3'd5) begin
                            idx_q   <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef AXI_ETH_RXS_FRAME_CNT_EN
    assign app3 = {16'h0000, fno_q};
`else
    assign app3 = 32'h0000_0000;
`endif

    // Status word select. Words depend only on registered state, so they hold while stalled.
    always_comb begin
        rxs_tvalid = (state_q == S_SEND);
        rxs_tkeep  = rxs_tvalid ? 4'hF : 4'h0;
        rxs_tlast  = rxs_tvalid & (idx_q == 3'd5);
        rxs_tdata  = 32'h0000_0000;
        if (rxs_tvalid) begin
            case (idx_q)
                3'd0:    rxs_tdata = 32'h5000_0000;
                3'd4:    rxs_tdata = app3;
                3'd5:    rxs_tdata = {16'h0000, len_q};
                default: rxs_tdata = 32'h0000_0000;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_eth_rxs.sv
// Self-checking bench for axi_eth_rxs. A frame-level model watches accepted
// beats, predicts each status packet, and checks every status word on handshake.
// Directed table vectors and sequences cover the corner cases.
module tb_axi_eth_rxs;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rx_reset;
    logic [63:0] mac_tdata;
    logic [7:0]  mac_tkeep;
    logic        mac_tlast;
    logic        mac_tvalid;
    logic        mac_tready;
    logic [63:0] rxd_tdata;
    logic [7:0]  rxd_tkeep;
    logic        rxd_tlast;
    logic        rxd_tvalid;
    logic        rxd_tready;
    logic [31:0] rxs_tdata;
    logic [3:0]  rxs_tkeep;
    logic        rxs_tlast;
    logic        rxs_tvalid;
    logic        rxs_tready;

    always #5 clk = ~clk;

    axi_eth_rxs #(.C_LEN_FIFO_DEPTH(DEPTH)) dut (
        .s2mm_clk   (clk),
        .rx_reset   (rx_reset),
        .mac_tdata  (mac_tdata),
        .mac_tkeep  (mac_tkeep),
        .mac_tlast  (mac_tlast),
        .mac_tvalid (mac_tvalid),
        .mac_tready (mac_tready),
        .rxd_tdata  (rxd_tdata),
        .rxd_tkeep  (rxd_tkeep),
        .rxd_tlast  (rxd_tlast),
        .rxd_tvalid (rxd_tvalid),
        .rxd_tready (rxd_tready),
        .rxs_tdata  (rxs_tdata),
        .rxs_tkeep  (rxs_tkeep),
        .rxs_tlast  (rxs_tlast),
        .rxs_tvalid (rxs_tvalid),
        .rxs_tready (rxs_tready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-level reference model
    typedef struct {
        logic [15:0] len;
        logic [15:0] fno;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned acc_model = 0;
    logic [15:0] fno_model = '0;
    int          widx = 0;
    int          status_words = 0;
    int          pkts_done = 0;
    logic [31:0] last_app3 = '0;
    logic [31:0] last_app4 = '0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    function automatic logic [15:0] sat16(input int unsigned a);
        return (a > 65535) ? 16'hFFFF : a[15:0];
    endfunction

    function automatic logic [31:0] exp_word(input int w, input exp_t e);
        case (w)
            0: return 32'h5000_0000;
`ifdef AXI_ETH_RXS_FRAME_CNT_EN
            4: return {16'h0000, e.fno};
`endif
            5: return {16'h0000, e.len};
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Handshake controls; this process is the only writer of the two ready inputs
    logic bp_rand   = 1'b0;
    logic rxd_force = 1'b1;
    logic rxs_force = 1'b1;

    initial begin
        rxd_tready = 1'b1;
        rxs_tready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (bp_rand) begin
                rxd_tready = ($urandom % 4) != 0;
                rxs_tready = ($urandom % 3) != 0;
            end else begin
                rxd_tready = rxd_force;
                rxs_tready = rxs_force;
            end
        end
    end

    // Monitor: sample on the falling edge, mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (rx_reset) begin
                acc_model = 0;
                exp_q.delete();
                fno_model = '0;
                widx = 0;
                prev_stall = 1'b0;
            end else begin
                if (mac_tvalid) begin
                    check("rxd_tdata", rxd_tdata, mac_tdata);
                    check("rxd_ctl", {rxd_tkeep, rxd_tlast}, {mac_tkeep, mac_tlast});
                end
                check("ready_gate", mac_tready & ~rxd_tready, 1'b0);
                check("hs_match", rxd_tvalid & rxd_tready, mac_tvalid & mac_tready);
                if (prev_stall) begin
                    check("rxs_hold", {rxs_tvalid, rxs_tdata}, {1'b1, prev_data});
                end
                if (mac_tvalid && mac_tready) begin
                    acc_model += $countones(mac_tkeep);
                    if (mac_tlast) begin
                        exp_q.push_back('{sat16(acc_model), fno_model});
                        fno_model = fno_model + 16'd1;
                        acc_model = 0;
                        check("status_lag", 64'(exp_q.size() <= DEPTH + 1), 1);
                    end
                end
                if (rxs_tvalid && rxs_tready) begin
                    status_words++;
                    check("status_expected", 64'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        check($sformatf("status_word%0d", widx), rxs_tdata, exp_word(widx, exp_q[0]));
                        check("status_tlast", rxs_tlast, 64'(widx == 5));
                        check("status_tkeep", rxs_tkeep, 4'hF);
                        if (widx == 4) last_app3 = rxs_tdata;
                        if (widx == 5) begin
                            last_app4 = rxs_tdata;
                            pkts_done++;
                            void'(exp_q.pop_front());
                            widx = 0;
                        end else begin
                            widx++;
                        end
                    end
                end
                prev_stall = rxs_tvalid && !rxs_tready;
                prev_data  = rxs_tdata;
            end
        end
    end

    // Driver tasks; the main process always resumes at posedge + 1
    task automatic do_reset();
        rx_reset = 1'b1;
        @(posedge clk);
        #1;
        rx_reset = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] keep, input logic last);
        int   budget = 2000;
        logic ok = 1'b0;
        mac_tvalid = 1'b1;
        mac_tdata  = {$urandom, $urandom};
        mac_tkeep  = keep;
        mac_tlast  = last;
        while (!ok && budget > 0) begin
            @(negedge clk);
            ok = mac_tready;
            @(posedge clk);
            #1;
            budget--;
        end
        if (!ok) check("beat_accept", ok, 1'b1);
        mac_tvalid = 1'b0;
        mac_tlast  = 1'b0;
    endtask

    task automatic send_frame(input int beats, input logic [7:0] km, input logic [7:0] kl);
        for (int b = 0; b < beats - 1; b++) send_beat(km, 1'b0);
        send_beat(kl, 1'b1);
    endtask

    task automatic wait_drain();
        int budget = 1000;
        while ((exp_q.size() != 0 || widx != 0) && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check("drain", 64'(exp_q.size()), 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        int          beats;
        logic [7:0]  km;
        logic [7:0]  kl;
        logic [15:0] exp_len;
    } vec_t;

    vec_t vecs[7];
    int   base;

    initial begin
        vecs[0] = '{3, 8'hFF, 8'h0F, 16'd20};
        vecs[1] = '{1, 8'h00, 8'h01, 16'd1};
        vecs[2] = '{1, 8'h00, 8'hA5, 16'd4};
        vecs[3] = '{2, 8'h81, 8'h00, 16'd2};
        vecs[4] = '{4, 8'h55, 8'hFF, 16'd20};
        vecs[5] = '{1, 8'h00, 8'h00, 16'd0};
        vecs[6] = '{5, 8'h7E, 8'h80, 16'd25};

        rx_reset   = 1'b1;
        mac_tvalid = 1'b0;
        mac_tdata  = '0;
        mac_tkeep  = '0;
        mac_tlast  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rx_reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_rxs_tvalid", rxs_tvalid, 1'b0);
        check("rst_rxs_tlast", rxs_tlast, 1'b0);
        check("rst_rxs_tdata", rxs_tdata, 32'h0);
        check("rst_mac_tready", mac_tready, 1'b1);
        @(posedge clk);
        #1;
        rxd_force = 1'b0;
        @(negedge clk);
        check("rst_mac_tready_low", mac_tready, 1'b0);
        @(posedge clk);
        #1;
        rxd_force = 1'b1;

        // Table-driven single frames
        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].beats, vecs[i].km, vecs[i].kl);
            wait_drain();
            check($sformatf("tbl_len%0d", i), last_app4, {16'h0, vecs[i].exp_len});
        end

        // Frame numbers restart at zero after reset
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send_frame(2, 8'hFF, 8'h03);
            wait_drain();
`ifdef AXI_ETH_RXS_FRAME_CNT_EN
            check("app3_fno", last_app3, 32'(i));
`else
            check("app3_zero", last_app3, 32'h0);
`endif
        end

        // Data backpressure mid-frame
        send_beat(8'hFF, 1'b0);
        send_beat(8'hFF, 1'b0);
        rxd_force  = 1'b0;
        mac_tvalid = 1'b1;
        mac_tkeep  = 8'hFF;
        repeat (10) begin
            @(negedge clk);
            check("bp_mac_tready", mac_tready, 1'b0);
            check("bp_rxd_tvalid", rxd_tvalid, 1'b1);
            @(posedge clk);
            #1;
        end
        rxd_force = 1'b1;
        send_beat(8'hFF, 1'b0);
        send_beat(8'h0F, 1'b1);
        wait_drain();
        check("bp_len", last_app4, 32'd28);

        // Length FIFO full: four queued entries plus one held by the stalled FSM
        rxs_force = 1'b0;
        base = pkts_done;
        for (int i = 0; i < 5; i++) send_beat(8'h01, 1'b1);
        repeat (5) begin
            @(negedge clk);
            check("full_mac_tready", mac_tready, 1'b0);
            @(posedge clk);
            #1;
        end
        rxs_force = 1'b1;
        wait_drain();
        check("full_pkts", 64'(pkts_done - base), 5);
        check("full_len", last_app4, 32'd1);

        // Saturation
        send_frame(8200, 8'hFF, 8'hFF);
        wait_drain();
        check("sat_len", last_app4, 32'h0000_FFFF);

        // Reset mid-frame discards the partial count
        base = pkts_done;
        send_beat(8'hFF, 1'b0);
        send_beat(8'hFF, 1'b0);
        do_reset();
        send_beat(8'h03, 1'b1);
        wait_drain();
        check("rstmid_len", last_app4, 32'd2);
        check("rstmid_pkts", 64'(pkts_done - base), 1);

        // Reset mid-status aborts the packet without a resend
        rxs_force = 1'b0;
        send_beat(8'hFF, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        base = status_words;
        rxs_force = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rxs_force = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        rxs_force = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1;
        end
        check("abort_words", 64'(status_words - base), 2);

        // Randomized traffic with random backpressure on both streams
        bp_rand = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int nb = 1 + ($urandom % 6);
            for (int b = 0; b < nb; b++) begin
                send_beat(8'($urandom), (b == nb - 1));
                if (($urandom % 4) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        bp_rand = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
